// File: rtl/nibble_packer.sv
// Packs up to LANES nibbles into one word; lane 0 holds the first nibble.
// Optional parity output is built only when NIBBLE_PACKER_PARITY_EN is defined.
module nibble_packer #(
    parameter int LANES = 5,
    parameter int NIBW  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [NIBW-1:0]               in_nibble,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [0:LANES-1][0:NIBW-1]    out_z,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_parity,
    output logic                          out_short,
    output logic [3:0]                    out_count
);

    // state | meaning
    // FILL  | accepting nibbles into lane idx
    // HOLD  | word complete, presented until out_ready
    typedef enum logic {FILL, HOLD} state_t;

    localparam int IDXW = $clog2(LANES);

    state_t                       state_q, state_d;
    logic [IDXW-1:0]              idx_q, idx_d;
    logic [0:LANES-1][0:NIBW-1]   lanes_q, lanes_d;
    logic                         short_q, short_d;
    logic [3:0]                   count_q, count_d;
    logic                         last_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            lanes_q <= '0;
            short_q <= 1'b0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            short_q <= short_d;
            count_q <= count_d;
        end
    end

    assign last_lane = (idx_q == IDXW'(LANES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        short_d = short_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    lanes_d[idx_q] = in_nibble;
                    count_d        = 4'(idx_q) + 4'd1;
                    if (last_lane || in_last) begin
                        state_d = HOLD;
                        short_d = !last_lane;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            HOLD: begin
                // Release clears the word so the next fill starts from lane 0 with zeros.
                if (out_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    lanes_d = '0;
                    short_d = 1'b0;
                    count_d = 4'd0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == HOLD);
        out_z     = lanes_q;
        out_short = short_q;
        out_count = count_q;
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    assign out_parity = ^lanes_q;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Directed and random checks of nibble_packer against a queue-free word model
// that builds expected words by shifting nibbles into place.
module tb_nibble_packer;

    localparam int LANES = 5;
    localparam int NIBW  = 4;
    localparam int W     = LANES * NIBW;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic [NIBW-1:0]            in_nibble;
    logic                       in_last;
    logic                       in_ready;
    logic [0:LANES-1][0:NIBW-1] out_z;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_parity;
    logic                       out_short;
    logic [3:0]                 out_count;

    int errors = 0;
    int checks = 0;

    nibble_packer #(.LANES(LANES), .NIBW(NIBW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_nibble (in_nibble),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_z     (out_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_parity(out_parity),
        .out_short (out_short),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [W-1:0] z);
`ifdef NIBBLE_PACKER_PARITY_EN
        return logic'($countones(z) % 2);
`else
        return 1'b0;
`endif
    endfunction

    logic [W-1:0] exp_z;
    logic [3:0]   exp_cnt;
    logic         exp_short;

    // Sends len nibbles; in_last on the final one if the word is short or force_last is set.
    task automatic send_word(input logic [3:0] nibs [8], input int len, input bit force_last,
                             input int gap_max);
        exp_z = '0;
        for (int i = 0; i < len; i++) begin
            int gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                tick();
                check("gap_out_valid", out_valid, 1'b0);
            end
            in_valid  = 1'b1;
            in_nibble = nibs[i];
            in_last   = (i == len - 1) && (len < LANES || force_last);
            check("fill_in_ready", in_ready, 1'b1);
            exp_z = exp_z | (W'(nibs[i]) << (NIBW * (LANES - 1 - i)));
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        exp_cnt   = 4'(len);
        exp_short = (len < LANES);
        check("word_out_valid", out_valid, 1'b1);
        check("word_in_ready", in_ready, 1'b0);
        check("word_out_z", out_z, exp_z);
        check("word_out_count", out_count, exp_cnt);
        check("word_out_short", out_short, exp_short);
        check("word_out_parity", out_parity, exp_parity(exp_z));
    endtask

    // Holds the word for hold cycles (upstream pushing meanwhile), then releases it.
    task automatic release_word(input int hold);
        if (hold > 0) out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_nibble = 4'hF;
            tick();
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_out_z", out_z, exp_z);
            check("hold_out_count", out_count, exp_cnt);
            check("hold_out_short", out_short, exp_short);
            check("hold_out_parity", out_parity, exp_parity(exp_z));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rel_out_valid", out_valid, 1'b0);
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_out_z", out_z, '0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_z"}, out_z, '0);
        check({tag, "_out_count"}, out_count, 4'd0);
        check({tag, "_out_short"}, out_short, 1'b0);
        check({tag, "_out_parity"}, out_parity, 1'b0);
    endtask

    initial begin
        logic [3:0] nibs [8];
        rst = 1'b1; in_valid = 1'b0; in_nibble = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_idle("reset");

        // Full word 1..5, out_ready high: valid for exactly one cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) nibs[i] = 4'(i + 1);
        send_word(nibs, 5, 1'b0, 0);
        check("full_z_const", out_z, 20'h12345);
        release_word(0);

        // Early close after A, B.
        nibs[0] = 4'hA; nibs[1] = 4'hB;
        send_word(nibs, 2, 1'b0, 0);
        check("short_z_const", out_z, 20'hAB000);
        release_word(0);

        // Backpressure for 10 cycles.
        for (int i = 0; i < LANES; i++) nibs[i] = 4'($urandom);
        send_word(nibs, 5, 1'b0, 0);
        release_word(10);

        // Reset mid-fill discards the partial word.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_nibble = 4'($urandom); tick();
        end
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle("midrst");
        for (int i = 0; i < LANES; i++) nibs[i] = 4'($urandom);
        send_word(nibs, 5, 1'b0, 0);
        release_word(1);

        // in_last on the final lane is still a full word.
        for (int i = 0; i < LANES; i++) nibs[i] = 4'($urandom);
        send_word(nibs, 5, 1'b1, 0);
        release_word(0);

        // Reset while holding discards the held word.
        for (int i = 0; i < LANES; i++) nibs[i] = 4'($urandom);
        out_ready = 1'b0;
        send_word(nibs, 3, 1'b0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle("holdrst");

        // Random words: lengths, gaps, in_last on final lane, hold times.
        for (int w = 0; w < 40; w++) begin
            int len = int'($urandom_range(LANES, 1));
            for (int i = 0; i < LANES; i++) nibs[i] = 4'($urandom);
            out_ready = 1'($urandom);
            send_word(nibs, len, 1'($urandom), 2);
            release_word(int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
